sc_input_conditioner: RTL

- Board-input front end sitting directly upstream of the top-level computer's memory-mapped I/O hub.
- Synchronises and debounces the raw KEY and SW pins.
- Presents stable levels, sticky key-press flags and switch-change pulses that the hub exposes to the CPU.
- The hub clears press flags via a clear strobe when the CPU acknowledges a key.

---
 rtl/sc_input_conditioner_pkg.sv | 14 +
 rtl/sc_input_conditioner_debounce_bit.sv | 50 +++++
 rtl/sc_input_conditioner.sv | 90 +++++++++
 3 files changed

// File: rtl/sc_input_conditioner_pkg.sv
// Shared constants for the board-input conditioner and its per-bit debouncer.
package sc_input_conditioner_pkg;

    localparam int   NUM_KEYS        = 4;
    localparam int   NUM_SW          = 10;

    // Idle pin levels: keys are active-low buttons, switches reset to "down".
    localparam logic KEY_RELEASE_LVL = 1'b1;
    localparam logic SW_RESET_LVL    = 1'b0;

    // Short debounce window so simulations finish in a handful of cycles.
    localparam int   DEBOUNCE_SIM    = 4;

endpackage

// File: rtl/sc_input_conditioner_debounce_bit.sv
// One input bit: SYNC_STAGES-deep synchroniser, then a counter that must see
// the synchronised level differ from the stable level for DEBOUNCE_CYCLES
// consecutive cycles before the stable level follows it.
module sc_debounce_bit #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   CNT_W           = 19,
    parameter logic RST_LVL         = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_din,
    output logic o_q,
    output logic o_flip
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_q;
    logic                   w_s;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign o_q    = r_q;
    // High on the cycle whose clock edge will move the stable level.
    assign o_flip = (w_s != r_q) && (r_cnt == CNT_MAX);

    // Plain flop chain into the clock domain, no logic between stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_sync <= {SYNC_STAGES{RST_LVL}};
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
    end

    // Count disagreement cycles; any agreement restarts the window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_q   <= RST_LVL;
        end else if (w_s == r_q) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_q   <= w_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sc_input_conditioner.sv
// Board-input front end: debounced key/switch levels, sticky key-press flags
// cleared by the I/O hub, and a one-cycle pulse on any switch change.
module sc_input_conditioner
    import sc_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_SW-1:0]   sw,
    input  logic                clr_valid,
    input  logic [NUM_KEYS-1:0] clr_mask,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_SW-1:0]   sw_stable,
    output logic                sw_change
);

    logic [NUM_KEYS-1:0] w_key_q;
    logic [NUM_KEYS-1:0] w_key_flip;
    logic [NUM_KEYS-1:0] w_key_set;
    logic [NUM_KEYS-1:0] w_key_clr;
    logic [NUM_SW-1:0]   w_sw_q;
    logic [NUM_SW-1:0]   w_sw_flip;
    logic [NUM_KEYS-1:0] r_key_press;
    logic                r_sw_flip_d;
    logic                r_sw_change;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        sc_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .RST_LVL        (KEY_RELEASE_LVL)
        ) u_db (
            .clock (clock),
            .reset (reset),
            .i_din (key_n[gi]),
            .o_q   (w_key_q[gi]),
            .o_flip(w_key_flip[gi])
        );
    end

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
        sc_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .RST_LVL        (SW_RESET_LVL)
        ) u_db (
            .clock (clock),
            .reset (reset),
            .i_din (sw[gi]),
            .o_q   (w_sw_q[gi]),
            .o_flip(w_sw_flip[gi])
        );
    end

    // A flip while the stable key level is still "released" is a press edge,
    // so the flag rises on the same edge key_down does.
    assign w_key_set = w_key_flip & w_key_q;
    assign w_key_clr = {NUM_KEYS{clr_valid}} & clr_mask;

    // Sticky press flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_key_press <= '0;
        else       r_key_press <= (r_key_press & ~w_key_clr) | w_key_set;
    end

    // Change pulse lands the cycle after sw_stable moves; any number of bits
    // flipping together collapse to one pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sw_flip_d <= 1'b0;
            r_sw_change <= 1'b0;
        end else begin
            r_sw_flip_d <= |w_sw_flip;
            r_sw_change <= r_sw_flip_d;
        end
    end

    assign key_down  = ~w_key_q;
    assign key_press = r_key_press;
    assign sw_stable = w_sw_q;
    assign sw_change = r_sw_change;

endmodule
